// File: rtl/axi_lite_master_v2.sv
// AXI4-Lite master: independent single-outstanding write and read engines
// driven by a simple user command port, with per-engine response timeouts.
module axi_lite_master_v2 #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [2:0] PROT   = 3'b000,
    parameter int         TO_CYC = 255,
    localparam int        STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic              wr_ready,
    output logic              wr_done,
    output logic              wr_err,
    output logic [1:0]        wr_resp,
    output logic              wr_timeout,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_done,
    output logic              rd_err,
    output logic [1:0]        rd_resp,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_timeout
);

    localparam int CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TO_CYC);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic              aw_v;
    logic              w_v;
    logic [STRB_W-1:0] wstrb_q;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              wr_acc;
    logic              rd_acc;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              r_hs;

    assign wr_acc = wr_req & (w_state == W_IDLE);
    assign rd_acc = rd_req & (r_state == R_IDLE);
    assign aw_hs  = aw_v & m_axi_awready;
    assign w_hs   = w_v & m_axi_wready;
    assign b_hs   = m_axi_bvalid & m_axi_bready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;

    assign m_axi_awprot  = PROT;
    assign m_axi_arprot  = PROT;
    assign m_axi_awvalid = aw_v;
    assign m_axi_wvalid  = w_v;
    assign m_axi_wstrb   = w_v ? wstrb_q : '0;
    assign m_axi_bready  = (w_state == W_RESP);
    assign m_axi_arvalid = (r_state == R_ADDR);
    assign m_axi_rready  = (r_state == R_DATA);
    assign wr_ready      = (w_state == W_IDLE);
    assign rd_ready      = (r_state == R_IDLE);

    // State registers for both engines
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next state: leave XFER once both address and data have handshaked
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (wr_req) w_next = W_XFER;
            W_XFER: begin
                if ((!aw_v || m_axi_awready) && (!w_v || m_axi_wready))
                    w_next = W_RESP;
            end
            W_RESP: if (m_axi_bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read next state
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (rd_req) r_next = R_ADDR;
            R_ADDR: if (m_axi_arready) r_next = R_DATA;
            R_DATA: if (m_axi_rvalid) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write payload, per-channel valids and completion capture
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axi_awaddr <= '0;
            m_axi_wdata  <= '0;
            wstrb_q      <= '0;
            aw_v         <= 1'b0;
            w_v          <= 1'b0;
            wr_done      <= 1'b0;
            wr_err       <= 1'b0;
            wr_resp      <= 2'b00;
        end else begin
            wr_done <= 1'b0;
            if (wr_acc) begin
                m_axi_awaddr <= wr_addr;
                m_axi_wdata  <= wr_data;
                wstrb_q      <= wr_strb;
                aw_v         <= 1'b1;
                w_v          <= 1'b1;
            end else begin
                if (aw_hs) aw_v <= 1'b0;
                if (w_hs) w_v <= 1'b0;
            end
            if (b_hs) begin
                wr_done <= 1'b1;
                wr_resp <= m_axi_bresp;
                wr_err  <= m_axi_bresp[1];
            end
        end
    end

    // Read address capture and completion capture
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axi_araddr <= '0;
            rd_done      <= 1'b0;
            rd_err       <= 1'b0;
            rd_resp      <= 2'b00;
            rd_data      <= '0;
        end else begin
            rd_done <= 1'b0;
            if (rd_acc) m_axi_araddr <= rd_addr;
            if (r_hs) begin
                rd_done <= 1'b1;
                rd_data <= m_axi_rdata;
                rd_resp <= m_axi_rresp;
                rd_err  <= m_axi_rresp[1];
            end
        end
    end

    // Write timeout: saturating busy-cycle count, sticky flag until next accept
    always_ff @(posedge aclk) begin
        if (areset || wr_acc) begin
            w_cnt      <= '0;
            wr_timeout <= 1'b0;
        end else if (w_state != W_IDLE && TO_CYC != 0 && w_cnt != TO_MAX) begin
            w_cnt <= w_cnt + CNT_W'(1);
            if (w_cnt + CNT_W'(1) == TO_MAX) wr_timeout <= 1'b1;
        end
    end

    // Read timeout: same scheme as the write engine
    always_ff @(posedge aclk) begin
        if (areset || rd_acc) begin
            r_cnt      <= '0;
            rd_timeout <= 1'b0;
        end else if (r_state != R_IDLE && TO_CYC != 0 && r_cnt != TO_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt + CNT_W'(1) == TO_MAX) rd_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_v2.sv
// Bench for axi_lite_master_v2: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model.
module tb_axi_lite_master_v2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] m_axi_awaddr;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_ready;
    logic          wr_done;
    logic          wr_err;
    logic [1:0]    wr_resp;
    logic          wr_timeout;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_done;
    logic          rd_err;
    logic [1:0]    rd_resp;
    logic [DW-1:0] rd_data;
    logic          rd_timeout;

    always #5 aclk = ~aclk;

    axi_lite_master_v2 #(
        .ADDR_W(AW), .DATA_W(DW), .PROT(3'b000), .TO_CYC(TO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_ready(wr_ready), .wr_done(wr_done),
        .wr_err(wr_err), .wr_resp(wr_resp), .wr_timeout(wr_timeout),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_done(rd_done), .rd_err(rd_err), .rd_resp(rd_resp),
        .rd_data(rd_data), .rd_timeout(rd_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: what each engine has been asked and what
    // has happened on the bus since the command was accepted.
    bit            mw_busy, mw_aw_ok, mw_w_ok, mw_to, mw_done, mw_err;
    logic [AW-1:0] mw_addr;
    logic [DW-1:0] mw_data;
    logic [SW-1:0] mw_strb;
    logic [1:0]    mw_resp;
    int            mw_age;
    bit            mr_busy, mr_ar_ok, mr_to, mr_done, mr_err;
    logic [AW-1:0] mr_addr;
    logic [DW-1:0] mr_data;
    logic [1:0]    mr_resp;
    int            mr_age;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mw_busy = 0; mw_aw_ok = 0; mw_w_ok = 0; mw_to = 0;
        mw_done = 0; mw_err = 0; mw_resp = 0; mw_age = 0;
        mw_addr = 0; mw_data = 0; mw_strb = 0;
        mr_busy = 0; mr_ar_ok = 0; mr_to = 0; mr_done = 0;
        mr_err = 0; mr_resp = 0; mr_age = 0; mr_addr = 0; mr_data = 0;
    endtask

    task automatic model_edge();
        if (areset) begin
            model_reset();
            return;
        end
        mw_done = 0;
        mr_done = 0;
        if (!mw_busy) begin
            if (wr_req) begin
                mw_busy = 1; mw_aw_ok = 0; mw_w_ok = 0;
                mw_addr = wr_addr; mw_data = wr_data; mw_strb = wr_strb;
                mw_age = 0; mw_to = 0;
            end
        end else begin
            if (mw_aw_ok && mw_w_ok && m_axi_bvalid) begin
                mw_busy = 0; mw_done = 1;
                mw_resp = m_axi_bresp; mw_err = m_axi_bresp[1];
            end
            if (!mw_aw_ok && m_axi_awready) mw_aw_ok = 1;
            if (!mw_w_ok && m_axi_wready) mw_w_ok = 1;
            mw_age++;
            if (TO > 0 && mw_age >= TO) mw_to = 1;
        end
        if (!mr_busy) begin
            if (rd_req) begin
                mr_busy = 1; mr_ar_ok = 0; mr_addr = rd_addr;
                mr_age = 0; mr_to = 0;
            end
        end else begin
            if (mr_ar_ok && m_axi_rvalid) begin
                mr_busy = 0; mr_done = 1; mr_data = m_axi_rdata;
                mr_resp = m_axi_rresp; mr_err = m_axi_rresp[1];
            end
            if (!mr_ar_ok && m_axi_arready) mr_ar_ok = 1;
            mr_age++;
            if (TO > 0 && mr_age >= TO) mr_to = 1;
        end
    endtask

    task automatic compare();
        bit wv;
        wv = mw_busy && !mw_w_ok;
        chk("wr_ready", wr_ready, !mw_busy);
        chk("awvalid", m_axi_awvalid, mw_busy && !mw_aw_ok);
        chk("wvalid", m_axi_wvalid, wv);
        chk("bready", m_axi_bready, mw_busy && mw_aw_ok && mw_w_ok);
        chk("awaddr", m_axi_awaddr, mw_addr);
        chk("wdata", m_axi_wdata, mw_data);
        chk("wstrb", m_axi_wstrb, wv ? mw_strb : 4'h0);
        chk("awprot", m_axi_awprot, 3'b000);
        chk("wr_done", wr_done, mw_done);
        chk("wr_err", wr_err, mw_err);
        chk("wr_resp", wr_resp, mw_resp);
        chk("wr_timeout", wr_timeout, mw_to);
        chk("rd_ready", rd_ready, !mr_busy);
        chk("arvalid", m_axi_arvalid, mr_busy && !mr_ar_ok);
        chk("rready", m_axi_rready, mr_busy && mr_ar_ok);
        chk("araddr", m_axi_araddr, mr_addr);
        chk("arprot", m_axi_arprot, 3'b000);
        chk("rd_done", rd_done, mr_done);
        chk("rd_err", rd_err, mr_err);
        chk("rd_resp", rd_resp, mr_resp);
        chk("rd_data", rd_data, mr_data);
        chk("rd_timeout", rd_timeout, mr_to);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge aclk);
        #1;
        compare();
    endtask

    task automatic idle_in();
        areset = 0; wr_req = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        rd_req = 0; rd_addr = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_bresp = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_rdata = 0; m_axi_rresp = 0;
    endtask

    initial begin
        model_reset();
        idle_in();
        areset = 1;
        cycle();
        cycle();
        areset = 0;
        cycle();
        chk("lit_rst_wr_ready", wr_ready, 1'b1);
        chk("lit_rst_rd_ready", rd_ready, 1'b1);
        chk("lit_rst_rd_data", rd_data, 32'h0);

        // Single write, both handshakes together, OKAY response
        wr_req = 1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        cycle();
        chk("lit_w1_awvalid", m_axi_awvalid, 1'b1);
        chk("lit_w1_awaddr", m_axi_awaddr, 32'h10);
        chk("lit_w1_wstrb", m_axi_wstrb, 4'hF);
        idle_in();
        m_axi_awready = 1; m_axi_wready = 1;
        cycle();
        chk("lit_w1_bready", m_axi_bready, 1'b1);
        chk("lit_w1_wstrb_lo", m_axi_wstrb, 4'h0);
        idle_in();
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        cycle();
        chk("lit_w1_done", wr_done, 1'b1);
        chk("lit_w1_err", wr_err, 1'b0);
        idle_in();
        cycle();
        chk("lit_w1_done_pulse", wr_done, 1'b0);

        // Data handshake three cycles ahead of the address handshake
        wr_req = 1; wr_addr = 32'h44; wr_data = 32'h0BADF00D; wr_strb = 4'h3;
        cycle();
        idle_in();
        m_axi_wready = 1;
        cycle();
        chk("lit_w2_wvalid", m_axi_wvalid, 1'b0);
        chk("lit_w2_awvalid", m_axi_awvalid, 1'b1);
        idle_in();
        for (int i = 0; i < 2; i++) cycle();
        chk("lit_w2_awheld", m_axi_awvalid, 1'b1);
        m_axi_awready = 1;
        cycle();
        chk("lit_w2_bready", m_axi_bready, 1'b1);
        idle_in();
        m_axi_bvalid = 1; m_axi_bresp = 2'b11;
        cycle();
        chk("lit_w2_done", wr_done, 1'b1);
        chk("lit_w2_resp", wr_resp, 2'b11);
        cycle();
        chk("lit_w2_single", wr_done, 1'b0);
        idle_in();
        cycle();

        // Read with SLVERR response
        rd_req = 1; rd_addr = 32'h20;
        cycle();
        chk("lit_r1_araddr", m_axi_araddr, 32'h20);
        idle_in();
        m_axi_arready = 1;
        cycle();
        chk("lit_r1_rready", m_axi_rready, 1'b1);
        idle_in();
        m_axi_rvalid = 1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
        cycle();
        chk("lit_r1_done", rd_done, 1'b1);
        chk("lit_r1_data", rd_data, 32'h12345678);
        chk("lit_r1_err", rd_err, 1'b1);
        chk("lit_r1_resp", rd_resp, 2'b10);
        idle_in();
        cycle();

        // Response withheld long enough to trip the timeout
        wr_req = 1; wr_addr = 32'h80; wr_data = 32'h1; wr_strb = 4'h1;
        cycle();
        for (int k = 1; k <= 10; k++) begin
            idle_in();
            m_axi_awready = (k == 1); m_axi_wready = (k == 1);
            cycle();
            chk("lit_to_flag", wr_timeout, k >= 4);
            chk("lit_to_bready", m_axi_bready, 1'b1);
        end
        idle_in();
        m_axi_bvalid = 1;
        cycle();
        chk("lit_to_done", wr_done, 1'b1);
        chk("lit_to_sticky", wr_timeout, 1'b1);
        idle_in();
        wr_req = 1; wr_addr = 32'h84;
        cycle();
        chk("lit_to_clear", wr_timeout, 1'b0);
        idle_in();
        m_axi_awready = 1; m_axi_wready = 1;
        cycle();
        idle_in();
        m_axi_bvalid = 1;
        cycle();
        idle_in();
        cycle();

        // Reset in the middle of concurrent address phases
        wr_req = 1; wr_addr = 32'hA0; wr_data = 32'h5; wr_strb = 4'hC;
        rd_req = 1; rd_addr = 32'hB0;
        cycle();
        chk("lit_rs_awvalid", m_axi_awvalid, 1'b1);
        chk("lit_rs_arvalid", m_axi_arvalid, 1'b1);
        idle_in();
        areset = 1;
        cycle();
        chk("lit_rs_awvalid0", m_axi_awvalid, 1'b0);
        chk("lit_rs_wvalid0", m_axi_wvalid, 1'b0);
        chk("lit_rs_arvalid0", m_axi_arvalid, 1'b0);
        chk("lit_rs_awaddr0", m_axi_awaddr, 32'h0);
        idle_in();
        cycle();
        chk("lit_rs_wr_ready", wr_ready, 1'b1);
        chk("lit_rs_rd_ready", rd_ready, 1'b1);
        chk("lit_rs_wr_done", wr_done, 1'b0);
        chk("lit_rs_rd_done", rd_done, 1'b0);

        // Randomized traffic on both engines with occasional resets
        for (int i = 0; i < 4000; i++) begin
            areset = ($urandom_range(0, 299) == 0);
            wr_req = ($urandom_range(0, 2) == 0);
            wr_addr = $urandom;
            wr_data = $urandom;
            wr_strb = 4'($urandom);
            rd_req = ($urandom_range(0, 2) == 0);
            rd_addr = $urandom;
            m_axi_awready = 1'($urandom);
            m_axi_wready = 1'($urandom);
            m_axi_bvalid = ($urandom_range(0, 3) == 0);
            m_axi_bresp = 2'($urandom);
            m_axi_arready = 1'($urandom);
            m_axi_rvalid = ($urandom_range(0, 3) == 0);
            m_axi_rdata = $urandom;
            m_axi_rresp = 2'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_v2.md
AXI_LITE_MASTER_V2 -- requirements
Module: axi_lite_master_v2

Interface
REQ-001 SHALL expose parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL expose parameter DATA_W, default 32, data width; legal values 32 or 64; STRB_W = DATA_W/8.
REQ-003 SHALL expose parameter PROT, default 3'b000, driven constantly on m_axi_awprot and m_axi_arprot.
REQ-004 SHALL expose parameter TO_CYC, default 255, response-wait timeout in cycles; 0 disables timeout.
REQ-005 SHALL have ports, in order:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
m_axi_aw{addr,prot,valid}  out  ADDR_W/3/1  write address channel; awready in 1
m_axi_w{data,strb,valid}  out  DATA_W/STRB_W/1  write data channel; wready in 1
m_axi_b{resp,valid}  in  2/1  write response; bready out 1
m_axi_ar{addr,prot,valid}  out  ADDR_W/3/1  read address channel; arready in 1
m_axi_r{data,resp,valid}  in  DATA_W/2/1  read data; rready out 1
wr_req, wr_addr, wr_data, wr_strb  in  1/ADDR_W/DATA_W/STRB_W  user write command
wr_ready  out  1  write engine idle, command accepted when wr_req & wr_ready
wr_done, wr_err, wr_resp  out  1/1/2  completion pulse, error flag, captured bresp
wr_timeout  out  1  sticky write timeout flag
rd_req, rd_addr  in  1/ADDR_W  user read command
rd_ready  out  1  read engine idle
rd_done, rd_err, rd_resp, rd_data  out  1/1/2/DATA_W  completion pulse, error, captured rresp, captured rdata
rd_timeout  out  1  sticky read timeout flag

Function
REQ-006 Write and read engines SHALL be independent and may run concurrently; one outstanding transaction per engine.
REQ-007 Write FSM states SHALL be W_IDLE, W_XFER, W_RESP; read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-008 wr_ready SHALL equal (state==W_IDLE); rd_ready SHALL equal (state==R_IDLE).
REQ-009 Write accept at cycle T SHALL register addr/data/strb and assert awvalid and wvalid at T+1 (W_XFER).
REQ-010 awvalid and wvalid SHALL each drop independently the cycle after their own handshake; payloads SHALL stay stable while valid.
REQ-011 W_XFER -> W_RESP when both handshakes complete (same or different cycles); bready SHALL be 1 only in W_RESP.
REQ-012 bvalid & bready at cycle N SHALL give W_IDLE, wr_done=1 for exactly one cycle, wr_resp=bresp, wr_err=bresp[1] at N+1; wr_resp/wr_err hold until next wr_done.
REQ-013 Read accept at T SHALL assert arvalid with registered address at T+1 (R_ADDR); arready handshake -> R_DATA, arvalid low next cycle; rready SHALL be 1 only in R_DATA.
REQ-014 rvalid & rready at N SHALL give R_IDLE, rd_done pulse, rd_data=rdata, rd_resp=rresp, rd_err=rresp[1] at N+1; held until next rd_done.
REQ-015 Back-to-back: command presented during the done cycle SHALL be accepted, next valid at done+1.
REQ-016 wr_req/rd_req while engine busy SHALL be ignored (no queueing).
REQ-017 Timeout counter per engine SHALL clear on accept and count each non-idle cycle; on reaching TO_CYC (TO_CYC>0) the sticky *_timeout flag SHALL set; FSM SHALL continue waiting (no valid withdrawn); flag clears on next accept.
REQ-018 Counter SHALL saturate at TO_CYC, never wrap.
REQ-019 m_axi_wstrb SHALL be 0 when wvalid low.

Reset
REQ-020 areset high at a rising edge SHALL force both FSMs idle, all valid/ready-to-slave outputs 0, done/err/timeout 0, wr_resp/rd_resp 0, rd_data 0, registered payloads 0, including mid-transaction.
REQ-021 wr_ready and rd_ready SHALL be 1 the first cycle after areset deasserts.

Verification
REQ-022 Write 0x10/0xDEADBEEF/strb 0xF, awready&wready same cycle, bresp=00 one cycle later -> wr_done pulse, wr_err=0, wr_resp=00.
REQ-023 wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, single bvalid accepted, one wr_done.
REQ-024 Read 0x20, rdata=0x12345678 rresp=10 -> rd_done, rd_data=0x12345678, rd_err=1, rd_resp=10.
REQ-025 TO_CYC=4, bvalid withheld 10 cycles -> wr_timeout set at 4th busy cycle, bready stays 1, wr_done on eventual bvalid; flag cleared on next accept.
REQ-026 Concurrent write and read with areset pulsed while both in address phase -> all valids 0 next cycle, both ready=1 after release, no done pulses.
